ofdm_bin_demapper: RTL
======================

Name: ofdm_bin_demapper

Overview:
- Receive-side consumer of the streamed 16-point FFT output: one complex bin per valid beat, with a cycle-done strobe on the last bin.
- Collects one 16-bin frame and computes an L1 magnitude per bin.
- Decides which of the four data subcarriers (bins 1, 2, 4, 8) are active and outputs a 4-bit symbol plus the peak-bin index over a valid/ready handshake.
- Recovers the tone pattern that was fed into the FFT.

Parameters:
- N, 16, width of each real/imag component, signed two's complement.
- Q, 8, fractional bits of the component format; informational only, no arithmetic depends on it.
- BINS, 16, bins per frame; fixed at 16 (index width 4).
- THRESH, 128, unsigned activity threshold compared against the (N+1)-bit magnitude.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_bin  in  2N  bin sample: [2N-1:N] is re, [N-1:0] is im, both signed.
- i_bin_valid  in  1  i_bin holds a bin this cycle.
- i_cycle_done  in  1  marks the last bin of a frame; only meaningful with i_bin_valid.
- o_symbol  out  4  {act8, act4, act2, act1}.
- o_peak_bin  out  4  index of the largest-magnitude bin.
- o_peak_mag  out  N+1  magnitude of the peak bin.
- o_valid  out  1  result registers hold an unconsumed frame result.
- i_ready  in  1  downstream accepts the result.
- o_frame_err  out  1  one-cycle pulse on frame misalignment.
- o_overrun  out  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset (sync): state COLLECT, bin index 0, accumulators cleared.
- Reset values: o_valid=0, o_symbol=0, o_peak_bin=0, o_peak_mag=0, o_frame_err=0, o_overrun=0.
- Reset asserted mid-frame discards the partial frame and any pending result.
- Magnitude: mag = |re| + |im|, unsigned N+1 bits, no saturation. |-2^(N-1)| = 2^(N-1) exactly.
- Accepted beat: i_bin_valid=1 while in COLLECT. Bin index increments on each beat and wraps 15 to 0.
- Activity flags: on the beat with index k in {1,2,4,8}, actk <= (mag >= THRESH).
- Peak tracking: running peak resets on index 0. Update only when mag > current peak (strict), so ties keep the lower index. Index 0 always loads.
- State COLLECT, last-beat handling (index 15):
  - If i_cycle_done=1, the frame is complete.
  - If o_valid=0, or o_valid=1 and i_ready=1 in the same cycle, load o_symbol/o_peak_bin/o_peak_mag (including the index-15 contribution) and set o_valid=1 on the next edge.
  - Latency: result visible 1 cycle after the index-15 beat.
  - Otherwise (o_valid=1 and i_ready=0) drop the new frame, keep the old result, and pulse o_overrun.
- State COLLECT, misalignment goes to SYNC and pulses o_frame_err. Two cases:
  - i_cycle_done=1 on index != 15.
  - i_cycle_done=0 on index 15.
- State SYNC:
  - Ignore bin data and output no result.
  - On a valid beat with i_cycle_done=1, go to COLLECT with index 0.
  - Beats without i_cycle_done stay in SYNC.
- Handshake:
  - Transfer when o_valid && i_ready; o_valid clears next cycle unless a new result loads in that same cycle.
  - Outputs are stable while o_valid=1 and i_ready=0.
  - i_ready is ignored while o_valid=0.
- i_bin_valid=0 cycles (gaps) inside a frame are allowed; index and accumulators hold.
- i_cycle_done without i_bin_valid is ignored.

Test Plan:
- Basic decode: one frame, all bins (0,0) except bin1=(256,0), bin2=(0,-512), bin4=(64,64), bin8=(-100,20); done on beat 15; i_ready=1.
  - Required: o_valid one cycle after beat 15, o_symbol=4'b0111, o_peak_bin=2, o_peak_mag=512.
- Tie/extreme: bin3=(-32768,0), bin5=(0,-32768), others 0.
  - Required: o_peak_mag=32768, o_peak_bin=3, o_symbol=0.
- Backpressure: i_ready=0 across two consecutive frames.
  - Required: the first result is held unchanged and o_overrun pulses once at the second frame's beat 15.
  - Then i_ready=1: transfer, o_valid=0 next cycle.
- Misalignment: i_cycle_done asserted on beat 9.
  - Required: o_frame_err pulse, no result.
  - Next 3 beats without done are ignored; a beat with done resyncs; the following full frame decodes correctly.
- Gaps: i_bin_valid deasserted for 3 cycles between beats 5 and 6 of the basic-decode frame.
  - Required: result identical to the gap-free case.
- Reset mid-frame: i_rst for 1 cycle at beat 7 while o_valid=1.
  - Required: o_valid=0 and all outputs 0 next cycle; the next 16-beat frame decodes normally from index 0.

Source files
------------

// File: rtl/ofdm_bin_demapper_if.sv
// Stream/result bundle for ofdm_bin_demapper.
// Input side: FFT bin stream (i_bin, i_bin_valid, i_cycle_done) plus the
// downstream ready (i_ready). Output side: decoded frame result (o_symbol,
// o_peak_bin, o_peak_mag, o_valid) and error pulses (o_frame_err, o_overrun).
// master = producer/consumer environment, slave = the demapper.
interface ofdm_bin_demapper_if #(
  parameter int unsigned N = 16
);
  logic [2*N-1:0] i_bin;
  logic           i_bin_valid;
  logic           i_cycle_done;
  logic [3:0]     o_symbol;
  logic [3:0]     o_peak_bin;
  logic [N:0]     o_peak_mag;
  logic           o_valid;
  logic           i_ready;
  logic           o_frame_err;
  logic           o_overrun;

  modport master (
    output i_bin, i_bin_valid, i_cycle_done, i_ready,
    input  o_symbol, o_peak_bin, o_peak_mag, o_valid, o_frame_err, o_overrun
  );

  modport slave (
    input  i_bin, i_bin_valid, i_cycle_done, i_ready,
    output o_symbol, o_peak_bin, o_peak_mag, o_valid, o_frame_err, o_overrun
  );
endinterface

// File: rtl/ofdm_bin_demapper.sv
// OFDM bin demapper: collects one 16-bin FFT frame, computes |re|+|im| per
// bin, flags activity on data subcarriers 1/2/4/8 and tracks the peak bin.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset
//   bus    - ofdm_bin_demapper_if.slave: bin stream in, frame result out
//            with valid/ready handshake, frame_err/overrun one-cycle pulses.
module ofdm_bin_demapper #(
  parameter int unsigned N      = 16,
  parameter int unsigned Q      = 8,
  parameter int unsigned BINS   = 16,
  parameter int unsigned THRESH = 128
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  ofdm_bin_demapper_if.slave   bus
);

  if (BINS != 16) begin : g_bins_chk
    $error("ofdm_bin_demapper supports BINS=16 only");
  end
  if (Q >= N) begin : g_q_chk
    $error("ofdm_bin_demapper: Q must be below N");
  end

  typedef enum logic {COLLECT, SYNC} state_t;

  localparam logic [N:0] THR = (N+1)'(THRESH);

  state_t       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [3:0]   act_q, act_d;
  logic [N:0]   peak_q, peak_d;
  logic [3:0]   peak_idx_q, peak_idx_d;
  logic [3:0]   symbol_q, symbol_d;
  logic [3:0]   peak_bin_q, peak_bin_d;
  logic [N:0]   peak_mag_q, peak_mag_d;
  logic         valid_q, valid_d;
  logic         frame_err_q, frame_err_d;
  logic         overrun_q, overrun_d;

  logic [N:0]   re_ext, im_ext, re_abs, im_abs, mag;
  logic [3:0]   act_nx;
  logic [N:0]   peak_nx;
  logic [3:0]   peak_idx_nx;

  always_comb begin
    // Sign-extend before negating so -2^(N-1) maps to +2^(N-1) exactly.
    re_ext = {bus.i_bin[2*N-1], bus.i_bin[2*N-1:N]};
    im_ext = {bus.i_bin[N-1],   bus.i_bin[N-1:0]};
    re_abs = re_ext[N] ? -re_ext : re_ext;
    im_abs = im_ext[N] ? -im_ext : im_ext;
    mag    = re_abs + im_abs;

    act_nx = act_q;
    case (idx_q)
      4'd1:    act_nx[0] = (mag >= THR);
      4'd2:    act_nx[1] = (mag >= THR);
      4'd4:    act_nx[2] = (mag >= THR);
      4'd8:    act_nx[3] = (mag >= THR);
      default: ;
    endcase

    // Strict compare keeps the lower index on ties; bin 0 always seeds.
    if (idx_q == 4'd0 || mag > peak_q) begin
      peak_nx     = mag;
      peak_idx_nx = idx_q;
    end else begin
      peak_nx     = peak_q;
      peak_idx_nx = peak_idx_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    act_d       = act_q;
    peak_d      = peak_q;
    peak_idx_d  = peak_idx_q;
    symbol_d    = symbol_q;
    peak_bin_d  = peak_bin_q;
    peak_mag_d  = peak_mag_q;
    valid_d     = valid_q & ~bus.i_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      COLLECT: begin
        if (bus.i_bin_valid) begin
          act_d      = act_nx;
          peak_d     = peak_nx;
          peak_idx_d = peak_idx_nx;
          if (idx_q == 4'd15) begin
            if (bus.i_cycle_done) begin
              idx_d = 4'd0;
              // Result slot is free if empty or being drained this cycle.
              if (!valid_q || bus.i_ready) begin
                symbol_d   = act_nx;
                peak_bin_d = peak_idx_nx;
                peak_mag_d = peak_nx;
                valid_d    = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
              state_d     = SYNC;
            end
          end else if (bus.i_cycle_done) begin
            frame_err_d = 1'b1;
            state_d     = SYNC;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      SYNC: begin
        if (bus.i_bin_valid && bus.i_cycle_done) begin
          state_d = COLLECT;
          idx_d   = 4'd0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      act_q       <= '0;
      peak_q      <= '0;
      peak_idx_q  <= '0;
      symbol_q    <= '0;
      peak_bin_q  <= '0;
      peak_mag_q  <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      act_q       <= act_d;
      peak_q      <= peak_d;
      peak_idx_q  <= peak_idx_d;
      symbol_q    <= symbol_d;
      peak_bin_q  <= peak_bin_d;
      peak_mag_q  <= peak_mag_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.o_symbol    = symbol_q;
  assign bus.o_peak_bin  = peak_bin_q;
  assign bus.o_peak_mag  = peak_mag_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_overrun   = overrun_q;

endmodule
